branch_predictor: RTL and testbench



---
 rtl/pipeline_types.sv | 51 +++++
 rtl/bht_counter_table.sv | 49 ++++
 rtl/branch_predictor.sv | 134 +++++++++++++
 tb/tb_branch_predictor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_types.sv
// -----------------------------------------------------------------------------
// pipeline_types
// Shared front-end types for the branch prediction unit:
//   bht_cnt_t       - 2-bit saturating direction counter encoding
//   btb_entry_t     - one branch target buffer entry {valid, tag, target}
//   branch_update_t - resolution record emitted by dispatch
//   bht_next()      - saturating counter step helper
// Default BPU geometry constants live here so the top and the sub-module agree.
// -----------------------------------------------------------------------------
package pipeline_types;

    localparam int BPU_BHT_INDEX_W = 8;
    localparam int BPU_BTB_INDEX_W = 6;
    localparam int BPU_BTB_TAG_W   = 10;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_t;

    typedef struct packed {
        logic                     valid;
        logic [BPU_BTB_TAG_W-1:0] tag;
        logic [31:0]              target;
    } btb_entry_t;

    typedef struct packed {
        logic [31:0] pc_dispatch;
        logic        update_en;
        logic        taken_or_not_actual;
        logic        branch_flush;
        logic [31:0] branch_actual_addr;
    } branch_update_t;

    // Saturating step: taken moves toward ST, not-taken toward SNT.
    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t res;
        res = cnt;
        case (cnt)
            SNT:     res = taken ? WNT : SNT;
            WNT:     res = taken ? WT  : SNT;
            WT:      res = taken ? ST  : WNT;
            ST:      res = taken ? ST  : WT;
            default: res = WNT;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bht_counter_table.sv
// -----------------------------------------------------------------------------
// bht_counter_table
// Direct-mapped array of 2-bit saturating direction counters.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (all counters -> WNT)
//   rd_idx      - read index (fetch side)
//   rd_cnt      - counter value at rd_idx (combinational)
//   wr_en       - apply a resolved-branch update this cycle
//   wr_idx      - index being updated
//   wr_taken    - actual direction of the resolved branch
// Configuration macro: BPU_BYPASS_EN - when defined, a read that hits the
// index being written returns the post-update counter.
// -----------------------------------------------------------------------------
module bht_counter_table
    import pipeline_types::*;
#(
    parameter int INDEX_W = BPU_BHT_INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_idx,
    output bht_cnt_t           rd_cnt,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic               wr_taken
);

    bht_cnt_t cnt_q [2**INDEX_W];
    bht_cnt_t wr_next;

    assign wr_next = bht_next(cnt_q[wr_idx], wr_taken);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**INDEX_W; i++) begin
                cnt_q[i] <= WNT;
            end
        end else if (wr_en) begin
            cnt_q[wr_idx] <= wr_next;
        end
    end

`ifdef BPU_BYPASS_EN
    assign rd_cnt = (wr_en && (wr_idx == rd_idx)) ? wr_next : cnt_q[rd_idx];
`else
    assign rd_cnt = cnt_q[rd_idx];
`endif

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Front-end branch prediction unit: BHT of 2-bit counters (bht_counter_table)
// plus an inline tagged direct-mapped BTB. One fetch PC in per cycle, registered
// prediction out one cycle later.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   fetch_en, pc_fetch   - fetch PC to predict, valid when fetch_en=1
//   stall                - hold the prediction outputs
//   flush                - kill the in-flight prediction (beats stall/fetch_en)
//   pre_valid            - prediction outputs valid
//   pre_is_branch_taken  - predicted taken
//   pre_branch_addr      - predicted target, 0 when not taken
//   update_en, pc_dispatch, taken_or_not_actual, branch_flush,
//   branch_actual_addr   - branch resolution record from dispatch
// Configuration macro: BPU_BYPASS_EN - when defined, a fetch colliding with an
// update on the same index sees the freshly written counter / BTB entry.
// -----------------------------------------------------------------------------
module branch_predictor
    import pipeline_types::*;
#(
    parameter int BHT_INDEX_W = BPU_BHT_INDEX_W,
    parameter int BTB_INDEX_W = BPU_BTB_INDEX_W,
    parameter int BTB_TAG_W   = BPU_BTB_TAG_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic [31:0] pc_fetch,
    input  logic        stall,
    input  logic        flush,
    output logic        pre_valid,
    output logic        pre_is_branch_taken,
    output logic [31:0] pre_branch_addr,
    input  logic        update_en,
    input  logic [31:0] pc_dispatch,
    input  logic        taken_or_not_actual,
    input  logic        branch_flush,
    input  logic [31:0] branch_actual_addr
);

    localparam int TAG_LSB = BTB_INDEX_W + 2;
    localparam int TAG_MSB = BTB_TAG_W + BTB_INDEX_W + 1;

    branch_update_t upd;

    assign upd.pc_dispatch         = pc_dispatch;
    assign upd.update_en           = update_en;
    assign upd.taken_or_not_actual = taken_or_not_actual;
    assign upd.branch_flush        = branch_flush;
    assign upd.branch_actual_addr  = branch_actual_addr;

    logic [BHT_INDEX_W-1:0] bht_rd_idx;
    logic [BHT_INDEX_W-1:0] bht_wr_idx;
    logic [BTB_INDEX_W-1:0] btb_rd_idx;
    logic [BTB_INDEX_W-1:0] btb_wr_idx;
    logic [BTB_TAG_W-1:0]   fetch_tag;
    logic [BTB_TAG_W-1:0]   dispatch_tag;

    assign bht_rd_idx   = pc_fetch[BHT_INDEX_W+1:2];
    assign bht_wr_idx   = upd.pc_dispatch[BHT_INDEX_W+1:2];
    assign btb_rd_idx   = pc_fetch[BTB_INDEX_W+1:2];
    assign btb_wr_idx   = upd.pc_dispatch[BTB_INDEX_W+1:2];
    assign fetch_tag    = pc_fetch[TAG_MSB:TAG_LSB];
    assign dispatch_tag = upd.pc_dispatch[TAG_MSB:TAG_LSB];

    // PC bits outside index/tag (including [1:0]) carry no prediction state.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_fetch[31:TAG_MSB+1], pc_fetch[1:0],
                              upd.pc_dispatch[31:TAG_MSB+1], upd.pc_dispatch[1:0]};

    bht_cnt_t bht_rd_cnt;

    bht_counter_table #(
        .INDEX_W (BHT_INDEX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (bht_rd_idx),
        .rd_cnt   (bht_rd_cnt),
        .wr_en    (upd.update_en),
        .wr_idx   (bht_wr_idx),
        .wr_taken (upd.taken_or_not_actual)
    );

    // BTB is only written for a taken mispredict; a correctly predicted taken
    // branch and any not-taken branch leave the existing entry untouched.
    btb_entry_t btb_q [2**BTB_INDEX_W];
    btb_entry_t btb_wr_entry;
    btb_entry_t btb_rd_entry;
    logic       btb_we;

    assign btb_we              = upd.update_en & upd.taken_or_not_actual & upd.branch_flush;
    assign btb_wr_entry.valid  = 1'b1;
    assign btb_wr_entry.tag    = dispatch_tag;
    assign btb_wr_entry.target = upd.branch_actual_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**BTB_INDEX_W; i++) begin
                btb_q[i].valid <= 1'b0;
            end
        end else if (btb_we) begin
            btb_q[btb_wr_idx] <= btb_wr_entry;
        end
    end

`ifdef BPU_BYPASS_EN
    assign btb_rd_entry = (btb_we && (btb_wr_idx == btb_rd_idx)) ? btb_wr_entry
                                                                  : btb_q[btb_rd_idx];
`else
    assign btb_rd_entry = btb_q[btb_rd_idx];
`endif

    logic        pred_taken;
    logic [31:0] pred_addr;

    assign pred_taken = bht_rd_cnt[1] & btb_rd_entry.valid & (btb_rd_entry.tag == fetch_tag);
    assign pred_addr  = pred_taken ? btb_rd_entry.target : 32'd0;

    // Output stage priority: reset, flush, stall (hold), fetch, idle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            pre_valid           <= 1'b0;
            pre_is_branch_taken <= 1'b0;
            pre_branch_addr     <= 32'd0;
        end else if (!stall) begin
            pre_valid           <= fetch_en;
            pre_is_branch_taken <= fetch_en & pred_taken;
            pre_branch_addr     <= fetch_en ? pred_addr : 32'd0;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Scoreboard bench for branch_predictor. The driver applies one directed vector
// per cycle and pushes the hand-computed prediction expected after the next
// posedge; an independent monitor pops and compares each cycle.
// Honours BPU_BYPASS_EN for the same-cycle collision vector.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] pc_fetch;
    logic        stall;
    logic        flush;
    logic        pre_valid;
    logic        pre_is_branch_taken;
    logic [31:0] pre_branch_addr;
    logic        update_en;
    logic [31:0] pc_dispatch;
    logic        taken_or_not_actual;
    logic        branch_flush;
    logic [31:0] branch_actual_addr;

    int tests_run  = 0;
    int tests_fail = 0;

    typedef struct {
        logic        v;
        logic        t;
        logic [31:0] a;
        string       name;
    } exp_t;

    exp_t sb [$];

    localparam logic [31:0] PC_A   = 32'h1C00_0000;
    localparam logic [31:0] PC_B   = 32'h1C00_0010;
    localparam logic [31:0] PC_AL  = 32'h1C00_1010;
    localparam logic [31:0] PC_C   = 32'h1C00_0020;
    localparam logic [31:0] TGT_B  = 32'h1C00_0100;
    localparam logic [31:0] TGT_C  = 32'h1C00_0200;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fetch_en            (fetch_en),
        .pc_fetch            (pc_fetch),
        .stall               (stall),
        .flush               (flush),
        .pre_valid           (pre_valid),
        .pre_is_branch_taken (pre_is_branch_taken),
        .pre_branch_addr     (pre_branch_addr),
        .update_en           (update_en),
        .pc_dispatch         (pc_dispatch),
        .taken_or_not_actual (taken_or_not_actual),
        .branch_flush        (branch_flush),
        .branch_actual_addr  (branch_actual_addr)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the prediction due one cycle later.
    task automatic apply_stimulus(
        input logic r, input logic fe, input logic [31:0] pc, input logic st, input logic fl,
        input logic ue, input logic [31:0] upc, input logic ut, input logic uf, input logic [31:0] ua,
        input logic ev, input logic et, input logic [31:0] ea, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n               = r;
        fetch_en            = fe;
        pc_fetch            = pc;
        stall               = st;
        flush               = fl;
        update_en           = ue;
        pc_dispatch         = upc;
        taken_or_not_actual = ut;
        branch_flush        = uf;
        branch_actual_addr  = ua;
        e.v    = ev;
        e.t    = et;
        e.a    = ea;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: compare the registered prediction shortly after each posedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_output({e.name, ".valid"}, {31'd0, pre_valid}, {31'd0, e.v});
                check_output({e.name, ".taken"}, {31'd0, pre_is_branch_taken}, {31'd0, e.t});
                check_output({e.name, ".addr"}, pre_branch_addr, e.a);
            end
        end
    end

    initial begin
        int waited;
        rst_n = 1'b0; fetch_en = 1'b0; pc_fetch = '0; stall = 1'b0; flush = 1'b0;
        update_en = 1'b0; pc_dispatch = '0; taken_or_not_actual = 1'b0;
        branch_flush = 1'b0; branch_actual_addr = '0;

        // Reset beats a concurrent fetch and update.
        apply_stimulus(0, 1, PC_B, 0, 0, 1, PC_B, 1, 1, 32'hDEAD_BEEF, 0, 0, 0, "reset0");
        apply_stimulus(0, 0, PC_A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset1");
        apply_stimulus(1, 1, PC_A, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "cold_fetch");
        // Taken mispredict installs BTB entry, counter 01->10.
        apply_stimulus(1, 0, PC_A, 0, 0, 1, PC_B, 1, 1, TGT_B, 0, 0, 0, "upd_install");
        apply_stimulus(1, 1, PC_B, 0, 0, 0, 0, 0, 0, 0, 1, 1, TGT_B, "pred_taken");
        // Correct taken update alongside fetch: counter 10->11.
        apply_stimulus(1, 1, PC_B, 0, 0, 1, PC_B, 1, 0, 0, 1, 1, TGT_B, "upd_fetch");
        apply_stimulus(1, 0, PC_A, 0, 0, 1, PC_B, 1, 0, 0, 0, 0, 0, "upd_sat_hi");
        apply_stimulus(1, 1, PC_AL, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "alias_tag");
        // 11->10 still predicts taken (catches wrap on increment).
        apply_stimulus(1, 0, PC_A, 0, 0, 1, PC_B, 0, 0, 0, 0, 0, 0, "nt1");
        apply_stimulus(1, 1, PC_B, 0, 0, 0, 0, 0, 0, 0, 1, 1, TGT_B, "after_sat_hi");
        apply_stimulus(1, 0, PC_A, 0, 0, 1, PC_B, 0, 0, 0, 0, 0, 0, "nt2");
        apply_stimulus(1, 0, PC_A, 0, 0, 1, PC_B, 0, 0, 0, 0, 0, 0, "nt3");
        apply_stimulus(1, 0, PC_A, 0, 0, 1, PC_B, 0, 0, 0, 0, 0, 0, "nt_sat_lo");
        apply_stimulus(1, 0, PC_A, 0, 0, 1, PC_B, 1, 0, 0, 0, 0, 0, "t_from_00");
        apply_stimulus(1, 1, PC_B, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "after_sat_lo");
        apply_stimulus(1, 0, PC_A, 0, 0, 1, PC_B, 1, 0, 0, 0, 0, 0, "t_to_10");
        apply_stimulus(1, 1, PC_B, 0, 0, 0, 0, 0, 0, 0, 1, 1, TGT_B, "btb_kept");
        // Same-cycle update and fetch on a fresh index.
`ifdef BPU_BYPASS_EN
        apply_stimulus(1, 1, PC_C, 0, 0, 1, PC_C, 1, 1, TGT_C, 1, 1, TGT_C, "collide");
`else
        apply_stimulus(1, 1, PC_C, 0, 0, 1, PC_C, 1, 1, TGT_C, 1, 0, 0, "collide");
`endif
        apply_stimulus(1, 1, PC_C, 0, 0, 0, 0, 0, 0, 0, 1, 1, TGT_C, "after_collide");
        apply_stimulus(1, 1, PC_B, 0, 0, 0, 0, 0, 0, 0, 1, 1, TGT_B, "pre_stall");
        // Stall freezes outputs; the update during stall must still land.
        apply_stimulus(1, 1, PC_A, 1, 0, 0, 0, 0, 0, 0, 1, 1, TGT_B, "stall1");
        apply_stimulus(1, 1, PC_A, 1, 0, 1, PC_C, 0, 0, 0, 1, 1, TGT_B, "stall2");
        apply_stimulus(1, 1, PC_A, 1, 0, 0, 0, 0, 0, 0, 1, 1, TGT_B, "stall3");
        apply_stimulus(1, 1, PC_B, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "flush");
        apply_stimulus(1, 1, PC_C, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "stall_upd_kept");
        apply_stimulus(1, 1, PC_B, 0, 0, 0, 0, 0, 0, 0, 1, 1, TGT_B, "pre_reset");
        apply_stimulus(0, 1, PC_B, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "mid_reset");
        apply_stimulus(1, 1, PC_B, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "lost_after_reset");
        apply_stimulus(1, 0, PC_B, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");

        @(negedge clk);
        fetch_en  = 1'b0;
        update_en = 1'b0;

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #3;
        if (sb.size() != 0) begin
            tests_run++;
            tests_fail++;
            $display("[TB] FAIL drain: %0d pending, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
